apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB4 requester that converts a simple valid/ready command stream into APB setup/access transfers and returns a registered response. It drives the APB bus of the UART register block from the host side, for example from a debug/command interface or the system bench. Supports wait states (`pready_i`), slave errors, a configurable access timeout, and local rejection of misaligned addresses.

## Interface
Parameters:
- `ADDR_W`, 12: APB address width.
- `DATA_W`, 32: APB data width; the strobe width is `DATA_W/8`.
- `TIMEOUT`, 16: maximum number of consecutive ACCESS cycles with `pready_i` low before the block aborts the transfer. A value of 0 disables the timeout.

Ports (the clock is `clk`; the reset is `reset_n`, asynchronous and active-low):
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous active-low reset
- `cmd_valid_i`  in  1  command present
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`
- `cmd_write_i`  in  1  1 = write, 0 = read
- `cmd_addr_i`  in  ADDR_W  byte address
- `cmd_wdata_i`  in  DATA_W  write data
- `cmd_strb_i`  in  DATA_W/8  write byte strobes
- `rsp_valid_o`  out  1  response present
- `rsp_ready_i`  in  1  response consumed
- `rsp_rdata_o`  out  DATA_W  read data; 0 for writes and for errors
- `rsp_err_o`  out  1  `pslverr_i`, timeout, or misalignment
- `rsp_timeout_o`  out  1  error was caused by timeout
- `psel_o`, `penable_o`, `pwrite_o`  out  1  APB controls
- `paddr_o`  out  ADDR_W;  `pwdata_o`  out  DATA_W;  `pstrb_o`  out  DATA_W/8
- `prdata_i`  in  DATA_W;  `pready_i`  in  1;  `pslverr_i`  in  1

## Operation
FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:** `cmd_ready_o` = 1.
  - On handshake, the block latches write, address, data, and strobe.
  - If `addr[1:0]` != 0, the block goes to RESP with `rsp_err_o` = 1 and performs no APB transfer.
  - Otherwise the block goes to SETUP.
- **SETUP:** `psel_o` = 1, `penable_o` = 0. The block always moves to ACCESS on the next cycle.
- **ACCESS:** `psel_o` = 1, `penable_o` = 1.
  - When `pready_i` = 1, the block captures `prdata_i` (reads only) and `pslverr_i`, then goes to RESP.
  - While `pready_i` = 0, the timeout counter increments.
  - When the counter reaches `TIMEOUT` (with `TIMEOUT` != 0), the block goes to RESP with `rsp_err_o` = 1, `rsp_timeout_o` = 1, and `rsp_rdata_o` = 0.
- **RESP:** `rsp_valid_o` = 1, and the response fields are held stable. The block returns to IDLE when `rsp_ready_i` = 1.
- APB control and data outputs:
  - `paddr_o`, `pwrite_o`, `pwdata_o`, and `pstrb_o` are registered. They are stable from SETUP through the end of ACCESS.
  - `pstrb_o` is forced to 0 for reads.
  - `pwdata_o` is driven to 0 for reads.
- Strobe and slave-error handling:
  - Write strobes are passed through unmodified, including 0.
  - When `pslverr_i` = 1 on a read, `rsp_rdata_o` = 0.
- The timeout counter is `$clog2(TIMEOUT+1)` bits wide. It clears on entry to SETUP and does not wrap.
- Only one transfer is outstanding at a time. `cmd_ready_o` is low in SETUP, ACCESS, and RESP.
- **Reset**, asynchronous and allowed at any point including mid-ACCESS:
  - The state returns to IDLE and all outputs drop immediately.
  - Any in-flight transfer and any pending response are discarded.
  - Reset values: `cmd_ready_o` = 1; `rsp_valid_o`, `rsp_err_o`, `rsp_timeout_o`, `psel_o`, `penable_o`, `pwrite_o` = 0; `paddr_o`, `pwdata_o`, `pstrb_o`, `rsp_rdata_o` = 0.

## Timing
- Let T be the command handshake cycle.
  - T+1: SETUP.
  - T+2: first ACCESS cycle.
  - With zero wait states, `rsp_valid_o` = 1 at T+3.
- Each cycle with `pready_i` low adds one cycle of latency.
- A misaligned command gives `rsp_valid_o` at T+1.
- Minimum command-to-command spacing is 4 cycles: IDLE, SETUP, ACCESS, RESP with `rsp_ready_i` already high.
- All outputs come directly from flops or from the state decode only. There is no combinational path from any input to any output.

## Structure
- Shared package `apb_pkg`:
  - State enum `apb_mst_state_e`.
  - Constants `APB_ADDR_W` = 12 and `APB_DATA_W` = 32.
  - UART register offsets: TX_DATA 0x0, RX_DATA 0x4, CFG 0x8, CTRL 0xC, STT 0x10. These are shared with the completer and the bench.
- One natural sub-module, `apb_wait_timer`: a saturating counter with `clear`, `inc`, and an `expired` output, parameterised by `TIMEOUT`. Everything else stays in `apb_master`.

## Test plan
- **Zero-wait write:** write to 0x008, data 0x0000001F, strobe 0xF, `pready_i` tied high.
  - Required: `psel_o` at T+1, `penable_o` at T+2, `paddr_o` = 0x008, `pstrb_o` = 0xF; `rsp_valid_o` at T+3 with `rsp_err_o` = 0.
- **Read with wait states:** read from 0x004; `pready_i` low for 3 ACCESS cycles, then high with `prdata_i` = 0xA5.
  - Required: `rsp_rdata_o` = 0x000000A5 at T+6, and `pstrb_o` = 0 throughout.
- **Slave error:** read from 0x014 with `pslverr_i` = 1.
  - Required: `rsp_err_o` = 1, `rsp_rdata_o` = 0, `rsp_timeout_o` = 0.
- **Timeout:** `TIMEOUT` = 16, `pready_i` held low.
  - Required: exactly 16 ACCESS cycles, then `rsp_err_o` = 1 and `rsp_timeout_o` = 1; `psel_o` drops in RESP.
- **Misaligned address and response backpressure:** command to 0x006, with `rsp_ready_i` low for 5 cycles.
  - Required: no `psel_o` ever asserted; `rsp_valid_o` at T+1 held for 5 cycles with stable fields; `cmd_ready_o` low until the response handshake.
- **Reset mid-ACCESS:** assert `reset_n` = 0 while `penable_o` = 1.
  - Required: `psel_o` and `penable_o` go to 0 immediately; no response is issued after reset; the next command proceeds normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: requester state encoding, default bus widths and
// the UART register map used by the completer and the benches.
// Latency: n/a. Backpressure: n/a.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_e;

  localparam int APB_ADDR_W = 12;
  localparam int APB_DATA_W = 32;

  // UART register block byte offsets
  localparam logic [APB_ADDR_W-1:0] UART_TX_DATA = 12'h000;
  localparam logic [APB_ADDR_W-1:0] UART_RX_DATA = 12'h004;
  localparam logic [APB_ADDR_W-1:0] UART_CFG     = 12'h008;
  localparam logic [APB_ADDR_W-1:0] UART_CTRL    = 12'h00C;
  localparam logic [APB_ADDR_W-1:0] UART_STT     = 12'h010;

  // Word transfers only: the two byte-offset bits must be zero.
  function automatic logic word_aligned(input logic [1:0] byte_off);
    return byte_off == 2'b00;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter used to bound an APB ACCESS phase.
// Latency: count updates one cycle after inc; expired is a decode of the count.
// Backpressure: none; clear has priority over inc.
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : zero the count (entry to SETUP)
//   inc          : one more wait cycle observed this cycle
//   expired      : high when one more inc makes the count reach TIMEOUT,
//                  so the requester can leave on exactly the TIMEOUT-th
//                  wait cycle; never high when TIMEOUT is 0
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  // TIMEOUT = 0 still needs a legal one-bit counter; it just never expires.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT      = CW'(TIMEOUT);
  localparam logic [CW-1:0] LIMIT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (TIMEOUT != 0) && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && (count == LIMIT_LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB4 requester: valid/ready command in, registered response out.
// Latency: cmd handshake T -> SETUP T+1 -> ACCESS T+2 -> rsp_valid T+3 (+1 per wait state);
//          misaligned commands answer at T+1 without touching the bus.
// Backpressure: cmd_ready_o only in IDLE; response held in RESP until rsp_ready_i.
//
// Ports:
//   clk, reset_n                     : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o          : command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i, cmd_strb_i          : command payload
//   rsp_valid_o/rsp_ready_i          : response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o                    : response payload
//   psel_o .. pstrb_o                : APB request outputs (all from flops/state)
//   prdata_i, pready_i, pslverr_i    : APB completer returns
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_strb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i
);

  apb_mst_state_e state, state_next;

  logic misaligned;
  logic accept;
  logic tmr_clear;
  logic tmr_inc;
  logic tmr_expired;
  logic done_ok;
  logic done_tmo;

  assign misaligned = !word_aligned(cmd_addr_i[1:0]);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and transfer-event decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    tmr_clear  = 1'b0;
    tmr_inc    = 1'b0;
    done_ok    = 1'b0;
    done_tmo   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          accept = 1'b1;
          if (misaligned) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_SETUP;
            tmr_clear  = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready_i) begin
          done_ok    = 1'b1;
          state_next = ST_RESP;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_expired) begin
            done_tmo   = 1'b1;
            state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Handshake and APB phase signals are pure state decodes, so reset drops
  // them the instant reset_n falls.
  assign cmd_ready_o = (state == ST_IDLE);
  assign psel_o      = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable_o   = (state == ST_ACCESS);
  assign rsp_valid_o = (state == ST_RESP);

  // ---------------------------------------------------------------------------
  // Wait-state timer
  // ---------------------------------------------------------------------------
  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  // ---------------------------------------------------------------------------
  // APB request registers: loaded only for aligned commands, so a rejected
  // command leaves the bus untouched. Read commands carry zero data/strobes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
      pstrb_o  <= '0;
    end else if (accept && !misaligned) begin
      pwrite_o <= cmd_write_i;
      paddr_o  <= cmd_addr_i;
      pwdata_o <= cmd_write_i ? cmd_wdata_i : '0;
      pstrb_o  <= cmd_write_i ? cmd_strb_i  : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers: written only on entry to RESP, so they stay stable
  // for as long as the response waits for rsp_ready_i.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else if (accept && misaligned) begin
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b1;
      rsp_timeout_o <= 1'b0;
    end else if (done_ok) begin
      // Read data is only meaningful for an error-free read.
      rsp_rdata_o   <= (!pwrite_o && !pslverr_i) ? prdata_i : '0;
      rsp_err_o     <= pslverr_i;
      rsp_timeout_o <= 1'b0;
    end else if (done_tmo) begin
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b1;
      rsp_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: expected responses are queued when a
// command is driven and compared when the response handshake is seen.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_apb_master;
  import apb_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [11:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [3:0]  cmd_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [11:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int   total;
  int   bad;
  rsp_t exp_q[$];

  apb_master #(
    .ADDR_W  (12),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_write_i   (cmd_write_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_wdata_i   (cmd_wdata_i),
    .cmd_strb_i    (cmd_strb_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .psel_o        (psel_o),
    .penable_o     (penable_o),
    .pwrite_o      (pwrite_o),
    .paddr_o       (paddr_o),
    .pwdata_o      (pwdata_o),
    .pstrb_o       (pstrb_o),
    .prdata_i      (prdata_i),
    .pready_i      (pready_i),
    .pslverr_i     (pslverr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one command at a falling edge (DUT must be idle), queues its
  // expected response, and returns at the falling edge of cycle T+1.
  task automatic start_cmd(input logic w, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s, input rsp_t e);
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_write_i = w;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
    cmd_strb_i  = s;
    exp_q.push_back(e);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, psel_o, penable_o, pwrite_o} !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=1000000",
               {cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o, psel_o, penable_o, pwrite_o});
    end
    total++;
    if ({paddr_o, pwdata_o, pstrb_o, rsp_rdata_o} !== 80'h0) begin
      bad++;
      $display("FAIL reset_data paddr=%h pwdata=%h pstrb=%h rdata=%h want all 0",
               paddr_o, pwdata_o, pstrb_o, rsp_rdata_o);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_write;
    rsp_t e;
    rsp_ready_i = 1'b1;
    pready_i    = 1'b1;
    start_cmd(1'b1, UART_CFG, 32'h0000_001F, 4'hF, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
    // T+1: SETUP
    total++;
    if ({psel_o, penable_o, pwrite_o, cmd_ready_o, rsp_valid_o} !== 5'b10100) begin
      bad++;
      $display("FAIL wr_setup_ctrl got=%b want=10100", {psel_o, penable_o, pwrite_o, cmd_ready_o, rsp_valid_o});
    end
    total++;
    if ({paddr_o, pwdata_o, pstrb_o} !== {12'h008, 32'h0000_001F, 4'hF}) begin
      bad++;
      $display("FAIL wr_setup_data paddr=%h pwdata=%h pstrb=%h want 008/0000001f/f", paddr_o, pwdata_o, pstrb_o);
    end
    @(negedge clk); // T+2: ACCESS
    total++;
    if ({psel_o, penable_o, rsp_valid_o} !== 3'b110) begin
      bad++;
      $display("FAIL wr_access_ctrl got=%b want=110", {psel_o, penable_o, rsp_valid_o});
    end
    @(negedge clk); // T+3: RESP
    total++;
    if ({rsp_valid_o, psel_o, penable_o} !== 3'b100) begin
      bad++;
      $display("FAIL wr_rsp_timing got=%b want=100", {rsp_valid_o, psel_o, penable_o});
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {e.rdata, e.err, e.tmo}) begin
        bad++;
        $display("FAIL wr_rsp rdata=%h err=%b tmo=%b want %h/%b/%b",
                 rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
      end
    end
    @(negedge clk); // T+4: back in IDLE
    total++;
    if ({cmd_ready_o, rsp_valid_o} !== 2'b10) begin
      bad++;
      $display("FAIL wr_idle got=%b want=10", {cmd_ready_o, rsp_valid_o});
    end
  endtask

  task automatic test_read_wait;
    rsp_t e;
    rsp_ready_i = 1'b1;
    pready_i    = 1'b0;
    prdata_i    = 32'h0;
    // Write data and strobes must not leak onto the bus for a read.
    start_cmd(1'b0, UART_RX_DATA, 32'hDEAD_BEEF, 4'hF, '{rdata: 32'h0000_00A5, err: 1'b0, tmo: 1'b0});
    for (int k = 1; k <= 5; k++) begin
      total++;
      if ({pstrb_o, pwdata_o, pwrite_o, psel_o, penable_o, rsp_valid_o} !== {4'h0, 32'h0, 1'b0, 1'b1, (k >= 2), 1'b0}) begin
        bad++;
        $display("FAIL rd_wait_cycle%0d pstrb=%h pwdata=%h pwrite=%b psel=%b pen=%b rv=%b want 0/0/0/1/%b/0",
                 k, pstrb_o, pwdata_o, pwrite_o, psel_o, penable_o, rsp_valid_o, (k >= 2));
      end
      if (k == 5) begin
        pready_i = 1'b1;
        prdata_i = 32'h0000_00A5;
      end
      @(negedge clk);
    end
    // T+6
    pready_i = 1'b0;
    total++;
    if (rsp_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL rd_rsp_timing rsp_valid=%b want=1 at T+6", rsp_valid_o);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {e.rdata, e.err, e.tmo}) begin
        bad++;
        $display("FAIL rd_rsp rdata=%h err=%b tmo=%b want %h/%b/%b",
                 rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_slave_error;
    rsp_t e;
    rsp_ready_i = 1'b1;
    pready_i    = 1'b1;
    pslverr_i   = 1'b1;
    prdata_i    = 32'hFFFF_FFFF;
    start_cmd(1'b0, 12'h014, 32'h0, 4'h0, '{rdata: 32'h0, err: 1'b1, tmo: 1'b0});
    repeat (2) @(negedge clk); // T+3
    pslverr_i = 1'b0;
    total++;
    if (rsp_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL slverr_timing rsp_valid=%b want=1", rsp_valid_o);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {e.rdata, e.err, e.tmo}) begin
        bad++;
        $display("FAIL slverr_rsp rdata=%h err=%b tmo=%b want %h/%b/%b",
                 rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    rsp_t e;
    int   n_access;
    bit   seen;
    rsp_ready_i = 1'b1;
    pready_i    = 1'b0;
    prdata_i    = 32'h1234_5678;
    n_access    = 0;
    seen        = 1'b0;
    start_cmd(1'b0, UART_CTRL, 32'h0, 4'h0, '{rdata: 32'h0, err: 1'b1, tmo: 1'b1});
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (penable_o) n_access++;
      if (rsp_valid_o) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL tmo_no_rsp rsp_valid never seen within 40 cycles, want response");
    end else begin
      total++;
      if (n_access != 16) begin
        bad++;
        $display("FAIL tmo_access_cycles got=%0d want=16", n_access);
      end
      total++;
      if ({psel_o, penable_o} !== 2'b00) begin
        bad++;
        $display("FAIL tmo_psel_in_resp got=%b want=00", {psel_o, penable_o});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {e.rdata, e.err, e.tmo}) begin
          bad++;
          $display("FAIL tmo_rsp rdata=%h err=%b tmo=%b want %h/%b/%b",
                   rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_misaligned_backpressure;
    rsp_t e;
    e = '{rdata: 32'h0, err: 1'b1, tmo: 1'b0};
    rsp_ready_i = 1'b0;
    pready_i    = 1'b1;
    start_cmd(1'b1, 12'h006, 32'hCAFE_F00D, 4'hF, e);
    // T+1 .. T+5: response held, bus idle, no new command accepted
    for (int k = 1; k <= 5; k++) begin
      total++;
      if ({rsp_valid_o, cmd_ready_o, psel_o, penable_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o}
          !== {1'b1, 1'b0, 1'b0, 1'b0, e.rdata, e.err, e.tmo}) begin
        bad++;
        $display("FAIL misalign_hold_cycle%0d rv=%b crdy=%b psel=%b pen=%b rdata=%h err=%b tmo=%b want 1/0/0/0/%h/%b/%b",
                 k, rsp_valid_o, cmd_ready_o, psel_o, penable_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
                 e.rdata, e.err, e.tmo);
      end
      if (k == 5) rsp_ready_i = 1'b1;
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    total++;
    if ({cmd_ready_o, rsp_valid_o, psel_o} !== 3'b100) begin
      bad++;
      $display("FAIL misalign_release got=%b want=100", {cmd_ready_o, rsp_valid_o, psel_o});
    end
  endtask

  task automatic test_reset_mid_access;
    rsp_t e;
    int   stray;
    rsp_ready_i = 1'b1;
    pready_i    = 1'b0;
    start_cmd(1'b0, UART_STT, 32'h0, 4'h0, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
    @(negedge clk); // T+2: ACCESS
    total++;
    if (penable_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_precond penable=%b want=1", penable_o);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({psel_o, penable_o, rsp_valid_o, cmd_ready_o} !== 4'b0001) begin
      bad++;
      $display("FAIL rst_mid_async got=%b want=0001", {psel_o, penable_o, rsp_valid_o, cmd_ready_o});
    end
    exp_q.delete(); // in-flight transfer is discarded
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid_o || psel_o) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL rst_mid_no_rsp stray_cycles=%0d want=0", stray);
    end
    // The next command must run normally.
    pready_i = 1'b1;
    start_cmd(1'b1, UART_TX_DATA, 32'h0000_0055, 4'h3, '{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
    total++;
    if ({psel_o, penable_o, pstrb_o, pwdata_o} !== {1'b1, 1'b0, 4'h3, 32'h0000_0055}) begin
      bad++;
      $display("FAIL rst_next_setup psel=%b pen=%b pstrb=%h pwdata=%h want 1/0/3/00000055",
               psel_o, penable_o, pstrb_o, pwdata_o);
    end
    repeat (2) @(negedge clk);
    total++;
    if (rsp_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_next_timing rsp_valid=%b want=1", rsp_valid_o);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {e.rdata, e.err, e.tmo}) begin
        bad++;
        $display("FAIL rst_next_rsp rdata=%h err=%b tmo=%b want %h/%b/%b",
                 rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
      end
    end
    @(negedge clk);
  endtask

  // Two commands presented back to back with rsp_ready high: the second is
  // accepted exactly four cycles after the first.
  task automatic test_back_to_back;
    rsp_t e;
    int   hs[2];
    int   n_hs;
    int   n_rsp;
    bit   swapped;
    rsp_ready_i = 1'b1;
    pready_i    = 1'b1;
    prdata_i    = 32'h0000_0022;
    n_hs        = 0;
    n_rsp       = 0;
    swapped     = 1'b0;
    hs[0]       = 0;
    hs[1]       = 0;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b1;
    cmd_addr_i  = UART_TX_DATA;
    cmd_wdata_i = 32'h0000_0041;
    cmd_strb_i  = 4'h1;
    for (int k = 0; k < 14; k++) begin
      if (n_hs == 1 && !swapped) begin
        swapped     = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = UART_CFG;
        cmd_wdata_i = 32'h0;
        cmd_strb_i  = 4'h0;
      end else if (n_hs == 2) begin
        cmd_valid_i = 1'b0;
      end
      if (rsp_valid_o && rsp_ready_i) begin
        n_rsp++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          total++;
          if ({rsp_rdata_o, rsp_err_o, rsp_timeout_o} !== {e.rdata, e.err, e.tmo}) begin
            bad++;
            $display("FAIL b2b_rsp%0d rdata=%h err=%b tmo=%b want %h/%b/%b",
                     n_rsp, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
          end
        end
      end
      if (cmd_valid_i && cmd_ready_o && n_hs < 2) begin
        hs[n_hs] = k;
        n_hs++;
        if (cmd_write_i) exp_q.push_back('{rdata: 32'h0, err: 1'b0, tmo: 1'b0});
        else             exp_q.push_back('{rdata: 32'h0000_0022, err: 1'b0, tmo: 1'b0});
      end
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    total++;
    if (n_hs != 2 || n_rsp != 2) begin
      bad++;
      $display("FAIL b2b_count handshakes=%0d responses=%0d want 2/2", n_hs, n_rsp);
    end
    total++;
    if (hs[1] - hs[0] != 4) begin
      bad++;
      $display("FAIL b2b_spacing got=%0d want=4", hs[1] - hs[0]);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    cmd_strb_i  = '0;
    rsp_ready_i = 1'b0;
    prdata_i    = '0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;

    test_reset();
    test_zero_wait_write();
    test_read_wait();
    test_slave_error();
    test_timeout();
    test_misaligned_backpressure();
    test_reset_mid_access();
    test_back_to_back();

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover entries=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
